transmitter_scheduler: RTL
==========================

Name: transmitter_scheduler

Overview:
Round-robin scheduler that shares one serial output lane between the channel buffers of the transmitter. It picks a non-empty channel and pops one word from it with a single-cycle acknowledge. It then serialises that word MSB-first into SYM_WIDTH-bit symbols, inserts an inter-word gap, and rearbitrates. It sits between the per-channel FIFO read ports and the LED/line output, in the read-clock domain.

Parameters:
CHANNELS, 3, number of requesting channels (2..4)
WORD_WIDTH, 16, bits per channel word; must be a multiple of SYM_WIDTH
SYM_WIDTH, 2, bits emitted per cycle
GAP_CYCLES, 1, idle cycles after each word (0..15)

Ports:
clk  input  1  single clock, rising edge
arst  input  1  asynchronous reset, active-high
ch_valid  input  CHANNELS  bit i high = channel i FIFO not empty
ch_data  input  CHANNELS*WORD_WIDTH  channel i word at [i*WORD_WIDTH +: WORD_WIDTH] (head of FIFO, show-ahead)
ch_ack  output  CHANNELS  one-hot, one-cycle pop strobe to the granted channel
sym_data  output  SYM_WIDTH  current symbol
sym_valid  output  1  sym_data carries a symbol this cycle
sym_first  output  1  first symbol of a word
sym_chan  output  2  channel index of the word being sent
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (arst high, async): state=IDLE; all outputs 0; shift register 0; symbol counter 0; last-grant pointer=CHANNELS-1, so channel 0 has priority first.
- FSM states: IDLE, SHIFT, GAP.
- IDLE, no ch_valid bit set: stay in IDLE; outputs 0.
- IDLE, any ch_valid bit set:
  - Grant the first set bit in order last+1, last+2, ... (mod CHANNELS).
  - In the same cycle: assert ch_ack[grant] combinationally for exactly that cycle.
  - Register ch_data slice into the shift register, grant into sym_chan, and update last:=grant.
  - Next state: SHIFT.
- SHIFT:
  - sym_valid=1; sym_data=shift_reg[MSB -: SYM_WIDTH].
  - Shift left by SYM_WIDTH each cycle; lasts exactly N=WORD_WIDTH/SYM_WIDTH cycles (8 at defaults).
  - sym_first=1 only in the first SHIFT cycle.
  - After the Nth symbol: go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: sym_valid=0, sym_data=0, sym_first=0; stay GAP_CYCLES cycles, then IDLE. sym_chan holds the last value.
- Latency: ack in cycle T; first symbol in T+1; last symbol in T+N.
- Back-to-back (GAP_CYCLES=0): next ack at T+N+1. Period per word = N+GAP_CYCLES+1 cycles.
- ch_valid and ch_data are sampled only in IDLE. Changes during SHIFT/GAP are ignored; no second ack until IDLE.
- Never more than one ch_ack bit high. Never ack a channel whose ch_valid is low.
- Pointer wrap: after grant CHANNELS-1, search restarts at 0.
- Fairness: with all channels continuously valid, grants cycle 0,1,2,0,...
- Reset mid-word: output goes to 0 immediately; the partial word is dropped (it was already popped); after release, arbitration restarts from channel 0.
- Reset released with ch_valid set: grant is taken on the first clock edge after deassertion, not during reset.

Test Plan:
- Single word: reset, ch_valid=3'b001, ch0=16'hA5C3, GAP=1. Expect ch_ack=001 for 1 cycle; next 8 cycles sym_data=2,2,1,1,3,0,0,3 with sym_valid=1; sym_first on first only; sym_chan=0; 1 gap cycle; busy low after.
- Round-robin: all three valid continuously, ch0=16'h1111, ch1=16'h2222, ch2=16'h3333. Expect grant order 0,1,2,0,1,2; ch_ack spacing 10 cycles; symbol stream matches each word.
- Skip empty: last grant=0, ch_valid=3'b101. Expect next grant=2 (not 1), then 0.
- Zero gap: GAP_CYCLES=0, ch1 always valid. Expect 8 symbols, 1 idle ack cycle, 8 symbols. sym_valid pattern 8 high / 1 low repeating.
- Ignore during shift: grant ch0; raise ch_valid[1] mid-SHIFT and toggle ch0 data. Expect serialized word unchanged; ch1 granted only after return to IDLE; exactly one ack per word.
- Reset mid-word: assert arst at 4th symbol. Expect all outputs 0 in the same cycle. After release with ch_valid=111, first grant is ch0.

Source files
------------

// File: rtl/transmitter_scheduler.sv
// Round-robin pick of one non-empty channel, pop it with a one-cycle ack, then serialise MSB-first.
// Latency: ack at T, symbols T+1..T+N, then GAP_CYCLES idle; inputs are ignored outside IDLE.
module transmitter_scheduler #(
  parameter int CHANNELS   = 3,
  parameter int WORD_WIDTH = 16,
  parameter int SYM_WIDTH  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic [CHANNELS-1:0]            ch_valid,
  input  logic [CHANNELS*WORD_WIDTH-1:0] ch_data,
  output logic [CHANNELS-1:0]            ch_ack,
  output logic [SYM_WIDTH-1:0]           sym_data,
  output logic                           sym_valid,
  output logic                           sym_first,
  output logic [1:0]                     sym_chan,
  output logic                           busy
);

  localparam int N     = WORD_WIDTH / SYM_WIDTH;
  localparam int CNT_W = ($clog2(N) > 4) ? $clog2(N) : 4;
  localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [1:0]       LAST_RST = 2'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      cnt;
  logic [1:0]            last;
  logic [1:0]            grant;
  logic [1:0]            rr_idx;
  logic                  grant_vld;
  logic                  take;

  // Search starts just after the previous winner so every requester is served in turn.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    rr_idx    = '0;
    for (int off = 1; off <= CHANNELS; off++) begin
      rr_idx = 2'((int'(last) + off) % CHANNELS);
      if (!grant_vld && ch_valid[rr_idx]) begin
        grant_vld = 1'b1;
        grant     = rr_idx;
      end
    end
  end

  // Gated by arst so no pop can be issued while the block is held in reset.
  assign take = (state == IDLE) && grant_vld && !arst;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_SYM) begin
          state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (cnt == LAST_GAP) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      shift_reg <= '0;
      cnt       <= '0;
      last      <= LAST_RST;
      sym_chan  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            shift_reg <= ch_data[int'(grant)*WORD_WIDTH +: WORD_WIDTH];
            sym_chan  <= grant;
            last      <= grant;
            cnt       <= '0;
          end
        end
        SHIFT: begin
          shift_reg <= shift_reg << SYM_WIDTH;
          cnt       <= (cnt == LAST_SYM) ? '0 : cnt + 1'b1;
        end
        GAP: begin
          cnt <= (cnt == LAST_GAP) ? '0 : cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    ch_ack    = '0;
    sym_valid = 1'b0;
    sym_first = 1'b0;
    sym_data  = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (take) begin
          ch_ack[grant] = 1'b1;
        end
      end
      SHIFT: begin
        sym_valid = 1'b1;
        sym_first = (cnt == '0);
        sym_data  = shift_reg[WORD_WIDTH-1 -: SYM_WIDTH];
      end
      default: ;
    endcase
  end

endmodule
